fetch_queue: RTL and testbench



---
 rtl/fetch_queue_pkg.sv | 19 +
 rtl/fetch_queue_if.sv | 47 ++++
 rtl/fetch_queue_storage.sv | 24 ++
 rtl/fetch_queue.sv | 106 ++++++++++
 tb/tb_fetch_queue.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/fetch_queue_pkg.sv
// rtl/fetch_queue_pkg.sv - shared instruction-record widths for fetch, fetch queue and decode
package fetch_queue_pkg;

    localparam int fq_address_width     = 64;
    localparam int fq_instruction_width = 32;
    localparam int fq_pid_size          = 20;
    localparam int fq_tid_size          = 16;
    localparam int fq_counter_width     = 64;
    localparam int fq_queue_depth       = 8;
    localparam int fq_ptr_width         = 3;

    // Record layout, most significant field first:
    // {instruction, address, is64Bit, pid, tid, majId}
    function automatic int fq_entry_width(input int aw, input int iw, input int pw,
                                          input int tw, input int cw);
        return iw + aw + 1 + pw + tw + cw;
    endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// rtl/fetch_queue_if.sv - fetch/decode side signal bundle of the fetch queue
interface fetch_queue_if
    import fetch_queue_pkg::*;
#(
    parameter int addressWidth            = fq_address_width,
    parameter int instructionWidth        = fq_instruction_width,
    parameter int PidSize                 = fq_pid_size,
    parameter int TidSize                 = fq_tid_size,
    parameter int instructionCounterWidth = fq_counter_width,
    parameter int ptrWidth                = fq_ptr_width
);
    logic                               enable_i;
    logic [instructionWidth-1:0]        instruction_i;
    logic [addressWidth-1:0]            instructionAddress_i;
    logic                               is64Bit_i;
    logic [PidSize-1:0]                 instructionPid_i;
    logic [TidSize-1:0]                 instructionTid_i;
    logic                               flush_i;
    logic                               stall_i;
    logic                               full_o;
    logic                               empty_o;
    logic [ptrWidth:0]                  count_o;
    logic                               overflow_o;
    logic                               enable_o;
    logic [instructionWidth-1:0]        instruction_o;
    logic [addressWidth-1:0]            instructionAddress_o;
    logic                               is64Bit_o;
    logic [PidSize-1:0]                 instructionPid_o;
    logic [TidSize-1:0]                 instructionTid_o;
    logic [instructionCounterWidth-1:0] instructionMajId_o;

    modport master (
        output enable_i, instruction_i, instructionAddress_i, is64Bit_i,
               instructionPid_i, instructionTid_i, flush_i, stall_i,
        input  full_o, empty_o, count_o, overflow_o, enable_o, instruction_o,
               instructionAddress_o, is64Bit_o, instructionPid_o,
               instructionTid_o, instructionMajId_o
    );

    modport slave (
        input  enable_i, instruction_i, instructionAddress_i, is64Bit_i,
               instructionPid_i, instructionTid_i, flush_i, stall_i,
        output full_o, empty_o, count_o, overflow_o, enable_o, instruction_o,
               instructionAddress_o, is64Bit_o, instructionPid_o,
               instructionTid_o, instructionMajId_o
    );
endinterface

// File: rtl/fetch_queue_storage.sv
// rtl/fetch_queue_storage.sv - register array with one write port and one read port
module fetch_queue_storage #(
    parameter int width = 1,
    parameter int depth = 8,
    parameter int ptr_w = 3
) (
    input  logic             clock_i,
    input  logic             we,
    input  logic [ptr_w-1:0] waddr,
    input  logic [width-1:0] wdata,
    input  logic [ptr_w-1:0] raddr,
    output logic [width-1:0] rdata
);
    logic [width-1:0] mem_q [depth];

    // Contents are qualified by the control's count, so no reset is needed.
    always_ff @(posedge clock_i) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch queue with major-ID stamping and registered output stage
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int addressWidth            = fq_address_width,
    parameter int instructionWidth        = fq_instruction_width,
    parameter int PidSize                 = fq_pid_size,
    parameter int TidSize                 = fq_tid_size,
    parameter int instructionCounterWidth = fq_counter_width,
    parameter int queueDepth              = fq_queue_depth,
    parameter int ptrWidth                = fq_ptr_width
) (
    input  logic          clock_i,
    input  logic          reset_i,
    fetch_queue_if.slave  fq
);
    localparam int entry_w = fq_entry_width(addressWidth, instructionWidth, PidSize,
                                            TidSize, instructionCounterWidth);

    logic [ptrWidth-1:0]                wp_q, wp_d, rp_q, rp_d;
    logic [ptrWidth:0]                  count_q, count_d;
    logic [instructionCounterWidth-1:0] maj_ctr_q, maj_ctr_d;
    logic                               overflow_q, overflow_d;
    logic                               enable_q, enable_d;
    logic [entry_w-1:0]                 out_q, out_d;
    logic [entry_w-1:0]                 wdata, rdata;
    logic                               full, push, pop;

    assign full  = (count_q == (ptrWidth+1)'(queueDepth));
    assign wdata = {fq.instruction_i, fq.instructionAddress_i, fq.is64Bit_i,
                    fq.instructionPid_i, fq.instructionTid_i, maj_ctr_q};

    fetch_queue_storage #(
        .width (entry_w),
        .depth (queueDepth),
        .ptr_w (ptrWidth)
    ) u_storage (
        .clock_i (clock_i),
        .we      (push),
        .waddr   (wp_q),
        .wdata   (wdata),
        .raddr   (rp_q),
        .rdata   (rdata)
    );

    // Push/pop decisions and next state; flush overrides push, pop and stall.
    always_comb begin
        push       = fq.enable_i && !full && !fq.flush_i;
        pop        = !fq.stall_i && !fq.flush_i && (count_q != '0);
        wp_d       = wp_q;
        rp_d       = rp_q;
        count_d    = count_q;
        enable_d   = enable_q;
        out_d      = out_q;
        maj_ctr_d  = maj_ctr_q + instructionCounterWidth'(push);
        // A push refused only because of a flush is not an overflow.
        overflow_d = overflow_q || (fq.enable_i && full && !fq.flush_i);
        if (fq.flush_i) begin
            wp_d     = '0;
            rp_d     = '0;
            count_d  = '0;
            enable_d = 1'b0;
        end else begin
            if (push) begin
                wp_d = wp_q + 1'b1;
            end
            if (pop) begin
                rp_d  = rp_q + 1'b1;
                out_d = rdata;
            end
            if (!fq.stall_i) begin
                enable_d = (count_q != '0);
            end
            count_d = count_q + (ptrWidth+1)'(push) - (ptrWidth+1)'(pop);
        end
    end

    // State registers; reset clears everything except the array contents.
    always_ff @(posedge clock_i or negedge reset_i) begin
        if (!reset_i) begin
            wp_q       <= '0;
            rp_q       <= '0;
            count_q    <= '0;
            maj_ctr_q  <= '0;
            overflow_q <= 1'b0;
            enable_q   <= 1'b0;
            out_q      <= '0;
        end else begin
            wp_q       <= wp_d;
            rp_q       <= rp_d;
            count_q    <= count_d;
            maj_ctr_q  <= maj_ctr_d;
            overflow_q <= overflow_d;
            enable_q   <= enable_d;
            out_q      <= out_d;
        end
    end

    assign fq.full_o     = full;
    assign fq.empty_o    = (count_q == '0);
    assign fq.count_o    = count_q;
    assign fq.overflow_o = overflow_q;
    assign fq.enable_o   = enable_q;
    assign {fq.instruction_o, fq.instructionAddress_o, fq.is64Bit_o,
            fq.instructionPid_o, fq.instructionTid_o, fq.instructionMajId_o} = out_q;
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed self-checking bench for fetch_queue
module tb_fetch_queue;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    always #5 clk = ~clk;

    fetch_queue_if bus ();

    fetch_queue dut (
        .clock_i (clk),
        .reset_i (rst_n),
        .fq      (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Instruction k carries a field pattern derived from k.
    task automatic drive(input logic en, input int k);
        logic [31:0] kv;
        kv = k;
        bus.enable_i             = en;
        bus.instruction_i        = 32'hA000_0000 | kv;
        bus.instructionAddress_i = 64'(kv) << 2;
        bus.is64Bit_i            = kv[0];
        bus.instructionPid_i     = 20'(32'h100 + kv);
        bus.instructionTid_i     = 16'(32'h50 + kv);
    endtask

    task automatic chk_out(input string tag, input int k, input logic [63:0] id);
        logic [31:0] kv;
        kv = k;
        chk({tag, ".en"},   64'(bus.enable_o), 64'd1);
        chk({tag, ".id"},   bus.instructionMajId_o, id);
        chk({tag, ".addr"}, bus.instructionAddress_o, 64'(kv) << 2);
        chk({tag, ".ins"},  64'(bus.instruction_o), 64'(32'hA000_0000 | kv));
        chk({tag, ".pid"},  64'(bus.instructionPid_o), 64'(20'(32'h100 + kv)));
        chk({tag, ".tid"},  64'(bus.instructionTid_o), 64'(16'(32'h50 + kv)));
        chk({tag, ".m64"},  64'(bus.is64Bit_o), 64'(kv[0]));
    endtask

    // Asynchronous reset pulse between edges; checked before any clock.
    task automatic do_reset(input string tag);
        bus.enable_i = 1'b0;
        bus.stall_i  = 1'b0;
        bus.flush_i  = 1'b0;
        rst_n = 1'b0;
        #1;
        chk({tag, ".en"},    64'(bus.enable_o), 64'd0);
        chk({tag, ".cnt"},   64'(bus.count_o), 64'd0);
        chk({tag, ".empty"}, 64'(bus.empty_o), 64'd1);
        chk({tag, ".full"},  64'(bus.full_o), 64'd0);
        chk({tag, ".ovf"},   64'(bus.overflow_o), 64'd0);
        chk({tag, ".id"},    bus.instructionMajId_o, 64'd0);
        chk({tag, ".addr"},  bus.instructionAddress_o, 64'd0);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.flush_i = 1'b0;
        bus.stall_i = 1'b0;
        drive(1'b0, 0);
        #12;
        chk("rst.en",    64'(bus.enable_o), 64'd0);
        chk("rst.empty", 64'(bus.empty_o), 64'd1);
        chk("rst.cnt",   64'(bus.count_o), 64'd0);
        chk("rst.ins",   64'(bus.instruction_o), 64'd0);
        rst_n = 1'b1;

        // Three pushes at 0x0, 0x4, 0x8; no bypass, one-cycle latency.
        drive(1'b1, 0); tick;
        chk("p3.e1.en",  64'(bus.enable_o), 64'd0);
        chk("p3.e1.cnt", 64'(bus.count_o), 64'd1);
        drive(1'b1, 1); tick;
        chk_out("p3.o0", 0, 64'd0);
        drive(1'b1, 2); tick;
        chk_out("p3.o1", 1, 64'd1);
        drive(1'b0, 0); tick;
        chk_out("p3.o2", 2, 64'd2);
        chk("p3.cnt", 64'(bus.count_o), 64'd0);
        tick;
        chk("p3.idle.en", 64'(bus.enable_o), 64'd0);
        chk("p3.hold.id", bus.instructionMajId_o, 64'd2);

        // Mid-operation reset clears the held output immediately.
        do_reset("arst1");

        // Stalled fill to full, then an overflowing push.
        bus.stall_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, k); tick;
        end
        chk("fill.full", 64'(bus.full_o), 64'd1);
        chk("fill.cnt",  64'(bus.count_o), 64'd8);
        chk("fill.ovf",  64'(bus.overflow_o), 64'd0);
        chk("fill.en",   64'(bus.enable_o), 64'd0);
        drive(1'b1, 8); tick;
        chk("ovf.set", 64'(bus.overflow_o), 64'd1);
        chk("ovf.cnt", 64'(bus.count_o), 64'd8);

        // Full queue, push and pop on one edge: push still dropped.
        drive(1'b1, 9);
        bus.stall_i = 1'b0;
        tick;
        chk("pp.cnt",  64'(bus.count_o), 64'd7);
        chk("pp.ovf",  64'(bus.overflow_o), 64'd1);
        chk("pp.full", 64'(bus.full_o), 64'd0);
        chk_out("drain0", 0, 64'd0);
        drive(1'b0, 0);
        for (int k = 1; k < 8; k++) begin
            tick;
            chk_out($sformatf("drain%0d", k), k, 64'(k));
        end
        tick;
        chk("drain.end.en",    64'(bus.enable_o), 64'd0);
        chk("drain.end.empty", 64'(bus.empty_o), 64'd1);
        chk("drain.ovf",       64'(bus.overflow_o), 64'd1);

        do_reset("arst2");

        // Flush while the output stage is valid; IDs continue afterwards.
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, k); tick;
        end
        chk_out("fl.pre", 3, 64'd3);
        chk("fl.pre.cnt", 64'(bus.count_o), 64'd1);
        bus.flush_i = 1'b1;
        drive(1'b1, 9); tick;
        chk("fl.en",    64'(bus.enable_o), 64'd0);
        chk("fl.cnt",   64'(bus.count_o), 64'd0);
        chk("fl.empty", 64'(bus.empty_o), 64'd1);
        chk("fl.hold",  bus.instructionMajId_o, 64'd3);
        bus.flush_i = 1'b0;
        drive(1'b1, 5); tick;
        chk("fl.post.en", 64'(bus.enable_o), 64'd0);
        drive(1'b0, 0); tick;
        chk_out("fl.next", 5, 64'd5);

        do_reset("arst3");

        // Stall while holding majId 2 for four cycles.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, k); tick;
        end
        chk_out("st.pre", 2, 64'd2);
        drive(1'b0, 0);
        bus.stall_i = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick;
            chk_out($sformatf("st.hold%0d", c), 2, 64'd2);
            chk($sformatf("st.cnt%0d", c), 64'(bus.count_o), 64'd1);
        end
        bus.stall_i = 1'b0;
        tick;
        chk_out("st.rel", 3, 64'd3);
        tick;
        chk("st.idle", 64'(bus.enable_o), 64'd0);

        // Major ID counter wrap.
        force dut.maj_ctr_q = 64'hFFFF_FFFF_FFFF_FFFE;
        #1;
        release dut.maj_ctr_q;
        drive(1'b1, 20); tick;
        drive(1'b1, 21); tick;
        chk_out("wrap0", 20, 64'hFFFF_FFFF_FFFF_FFFE);
        drive(1'b1, 22); tick;
        chk_out("wrap1", 21, 64'hFFFF_FFFF_FFFF_FFFF);
        drive(1'b0, 0); tick;
        chk_out("wrap2", 22, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
